// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and payload type
// for the 1-to-2 buffered demultiplexer.
package demux_pkg;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 2;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/chan_fifo.sv
// chan_fifo: per-channel synchronous FIFO.
// Registered head output, no write-to-read fall-through.
module chan_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH  = demux_pkg::DEPTH,
    parameter int DATA_W = demux_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = ready && valid;
    assign rdata   = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since valid gates the head
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/demux1x2_3bit_buf.sv
// demux1x2_3bit_buf: steers upstream beats into one
// of two buffered output channels (select or alternate).
module demux1x2_3bit_buf
    import demux_pkg::*;
#(
    parameter int DEPTH  = demux_pkg::DEPTH,
    parameter int DATA_W = demux_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              alt_mode,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              full0,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic              full1
);

    logic alt_ptr;
    logic dst;
    logic accept;

    assign dst      = alt_mode ? alt_ptr : in_sel;
    assign in_ready = dst ? !full1 : !full0;
    assign accept   = in_valid && in_ready;

    // Alternation pointer advances only on accepted beats in alt mode
    always_ff @(posedge clk) begin
        if (reset)                   alt_ptr <= 1'b0;
        else if (accept && alt_mode) alt_ptr <= !alt_ptr;
    end

    chan_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ch0 (
        .clk   (clk),
        .reset (reset),
        .push  (accept && !dst),
        .wdata (in_data),
        .ready (out0_ready),
        .valid (out0_valid),
        .rdata (out0_data),
        .full  (full0)
    );

    chan_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ch1 (
        .clk   (clk),
        .reset (reset),
        .push  (accept && dst),
        .wdata (in_data),
        .ready (out1_ready),
        .valid (out1_valid),
        .rdata (out1_data),
        .full  (full1)
    );

endmodule

// File: tb/tb_demux1x2_3bit_buf.sv
// tb_demux1x2_3bit_buf: queue-based scoreboard bench
// with directed scenarios followed by random traffic.
module tb_demux1x2_3bit_buf;
    import demux_pkg::*;

    localparam int DEPTH = 2;

    logic  clk = 1'b0;
    logic  reset;
    logic  in_valid;
    data_t in_data;
    logic  in_sel;
    logic  alt_mode;
    logic  in_ready;
    logic  out0_valid;
    data_t out0_data;
    logic  out0_ready;
    logic  full0;
    logic  out1_valid;
    data_t out1_data;
    logic  out1_ready;
    logic  full1;

    demux1x2_3bit_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .alt_mode   (alt_mode),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .full0      (full0),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .full1      (full1)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    data_t q0[$];
    data_t q1[$];
    bit    alt_m = 1'b0;
    bit    run   = 1'b0;
    int    occ0  = 0;
    int    occ1  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare channel heads with the reference queues
    always @(negedge clk) begin
        if (run) begin
            occ0 = q0.size();
            occ1 = q1.size();
            chk("out0_valid", int'(out0_valid), int'(occ0 != 0));
            chk("out1_valid", int'(out1_valid), int'(occ1 != 0));
            chk("full0", int'(full0), int'(occ0 == DEPTH));
            chk("full1", int'(full1), int'(occ1 == DEPTH));
            if (occ0 != 0) chk("out0_data", int'(out0_data), int'(q0[0]));
            if (occ1 != 0) chk("out1_data", int'(out1_data), int'(q1[0]));
            if (occ0 != 0 && out0_ready) void'(q0.pop_front());
            if (occ1 != 0 && out1_ready) void'(q1.pop_front());
        end
    end

    // One clock of stimulus; entered and left at posedge + 1
    task automatic step(input logic v, input data_t d, input logic sel,
                        input logic alt, input logic r0, input logic r1);
        bit dst_m;
        bit rdy_m;
        in_valid   = v;
        in_data    = d;
        in_sel     = sel;
        alt_mode   = alt;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        #1;
        dst_m = alt ? alt_m : sel;
        rdy_m = dst_m ? (occ1 < DEPTH) : (occ0 < DEPTH);
        chk("in_ready", int'(in_ready), int'(rdy_m));
        if (v && rdy_m) begin
            if (dst_m) q1.push_back(d);
            else       q0.push_back(d);
            if (alt) alt_m = !alt_m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        alt_mode   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        alt_m = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out0_valid", int'(out0_valid), 0);
        chk("rst_out1_valid", int'(out1_valid), 0);
        chk("rst_out0_data", int'(out0_data), 0);
        chk("rst_out1_data", int'(out1_data), 0);
        chk("rst_full0", int'(full0), 0);
        chk("rst_full1", int'(full1), 0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        alt_mode   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        do_reset();

        // select mode, back-to-back to out0
        step(1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // alternating mode: 1,3 to out0 and 2,4 to out1
        step(1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // fill out1, stall, single pop, late accept
        do_reset();
        step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // other channel still accepts while out1 is full
        step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // reset discards buffered beats
        step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // alt target full: pointer held through the stall
        do_reset();
        step(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0),
                     data_t'($urandom),
                     1'($urandom),
                     1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 2) != 0));
            end
        end
        drain();

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1x2_3bit_buf.md
DEMUX1X2_3BIT_BUF -- requirements
Module: demux1x2_3bit_buf

Interface
REQ-001 Parameter DEPTH, default 2: entries per output-channel buffer; legal values are powers of two, 2..8.
REQ-002 Parameter DATA_W, default 3: payload width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_data  input  DATA_W  upstream payload.
REQ-007 in_sel  input  1  destination when alt_mode=0 (0 -> out0, 1 -> out1).
REQ-008 alt_mode  input  1  1 = ignore in_sel and alternate destinations per accepted beat.
REQ-009 in_ready  output  1  upstream beat accepted this cycle when in_valid=1 and in_ready=1.
REQ-010 out0_valid / out1_valid  output  1  channel head entry valid.
REQ-011 out0_data / out1_data  output  DATA_W  channel head payload.
REQ-012 out0_ready / out1_ready  input  1  downstream consumes head when valid=1 and ready=1.
REQ-013 full0 / full1  output  1  channel buffer holds DEPTH entries.

Function
REQ-014 Destination (dst): in_sel when alt_mode=0; alternation pointer alt_ptr when alt_mode=1.
REQ-015 in_ready = NOT full of dst, evaluated combinationally from registered state only, with no dependence on out*_ready.
REQ-016 Accepted beat writes in_data into the dst buffer; the other buffer is untouched.
REQ-017 Latency: a beat accepted in cycle N shows on outX_valid/outX_data in cycle N+1 at the earliest; no combinational fall-through.
REQ-018 Each buffer is FIFO-ordered; outX_data is stable while outX_valid=1 and outX_ready=0.
REQ-019 Occupancy per channel: +1 on push, -1 on pop, unchanged on simultaneous push+pop.
REQ-020 Full channel: no push (in_ready=0); a pop in the same cycle frees a slot visible next cycle only.
REQ-021 Empty channel: outX_valid=0; ready ignored; a push in that cycle makes valid=1 next cycle.
REQ-022 Read/write pointers wrap modulo DEPTH; no data corruption across wrap.
REQ-023 alt_ptr toggles only on an accepted beat while alt_mode=1; held otherwise, including stalls.
REQ-024 alt_mode change takes effect on the next cycle's dst; alt_ptr is not cleared by the mode change.
REQ-025 Both channels may pop in the same cycle independently of any push.
REQ-026 A stalled upstream beat (in_valid=1, in_ready=0) is not recorded; the upstream holds it.

Reset
REQ-027 reset=1 at a clock edge clears all pointers/occupancy, alt_ptr=0, out0_valid=out1_valid=0, full0=full1=0, out*_data=0.
REQ-028 Reset mid-operation discards all buffered beats; no pop or push takes effect in the reset cycle.
REQ-029 First cycle after reset: in_ready=1.

Structure
REQ-030 Package demux_pkg holds DATA_W, default DEPTH, and typedef data_t (logic [DATA_W-1:0]).
REQ-031 One sub-module chan_fifo (synchronous FIFO: push, pop, data, valid, full), instantiated twice.
REQ-032 Top level holds only dst selection, alt_ptr register and ready gating.

Verification
REQ-033 alt_mode=0, in_sel=0, beats 3,5 back-to-back, out0_ready=1 -> out0 shows 3 then 5, one cycle after each accept; out1_valid stays 0.
REQ-034 alt_mode=1, beats 1,2,3,4, both readies=1 -> out0 gets 1,3; out1 gets 2,4; alt_ptr ends 0.
REQ-035 DEPTH=2, in_sel=1, out1_ready=0, beats 6,7,0 -> full1=1 after 2 accepts; in_ready=0 for beat 0; out1_ready=1 for 1 cycle -> 6 popped, beat 0 accepted the next cycle.
REQ-036 Channel full, push to other channel (in_sel=0, value 4) -> accepted immediately; full channel unchanged.
REQ-037 Load 2 beats into out0, assert reset 1 cycle -> out0_valid=0, in_ready=1, alt_ptr=0; next beat 2 emerges alone.
REQ-038 alt_mode=1, in_valid=1 with target full for 3 cycles -> alt_ptr held; first accepted beat still goes to the stalled target.
